// File: rtl/control_pkg.sv
// control_pkg: state codes, opcodes, mux select encodings and control bundle for the multicycle FSM
package control_pkg;
  localparam logic [3:0] S_FETCH      = 4'd0;
  localparam logic [3:0] S_DECODE     = 4'd1;
  localparam logic [3:0] S_MEMADR     = 4'd2;
  localparam logic [3:0] S_MEMREAD    = 4'd3;
  localparam logic [3:0] S_MEMWB      = 4'd4;
  localparam logic [3:0] S_EXEC_R     = 4'd5;
  localparam logic [3:0] S_EXEC_I     = 4'd6;
  localparam logic [3:0] S_EXEC_LUI   = 4'd7;
  localparam logic [3:0] S_EXEC_AUIPC = 4'd8;
  localparam logic [3:0] S_ALUWB      = 4'd9;
  localparam logic [3:0] S_TRAP       = 4'd10;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [1:0] ASRC_PC   = 2'b00;
  localparam logic [1:0] ASRC_OLD  = 2'b01;
  localparam logic [1:0] ASRC_REG  = 2'b10;
  localparam logic [1:0] ASRC_ZERO = 2'b11;
  localparam logic [1:0] BSRC_REG  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       reg_write;
    logic       imn_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       illegal;
  } ctrl_t;
  function automatic logic [3:0] decode_next(input logic [6:0] op);
    return op == OP_LW    ? S_MEMADR :
           op == OP_R     ? S_EXEC_R :
           op == OP_I     ? S_EXEC_I :
           op == OP_LUI   ? S_EXEC_LUI :
           op == OP_AUIPC ? S_EXEC_AUIPC : S_TRAP;
  endfunction
endpackage

// File: rtl/control_salidas.sv
// control_salidas: combinational decode of state (plus mem_ready in FETCH) into datapath controls
module control_salidas
  import control_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.adr_src = 1'b0;
        ctrl.pc_write = mem_ready;
        ctrl.ir_write = mem_ready;
        ctrl.alu_src_a = mem_ready ? ASRC_PC : 2'b00;
        ctrl.alu_src_b = mem_ready ? BSRC_FOUR : 2'b00;
        ctrl.result_src = mem_ready ? RES_ALU : 2'b00;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = ASRC_REG;
        ctrl.alu_src_b = BSRC_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write = 1'b1;
        ctrl.retire = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = ASRC_REG;
        ctrl.alu_src_b = BSRC_REG;
        ctrl.alu_op = ALUOP_R;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = ASRC_REG;
        ctrl.alu_src_b = BSRC_IMM;
        ctrl.alu_op = ALUOP_I;
      end
      S_EXEC_LUI: begin
        ctrl.alu_src_a = ASRC_ZERO;
        ctrl.alu_src_b = BSRC_IMM;
        ctrl.imn_src = 1'b1;
      end
      S_EXEC_AUIPC: begin
        ctrl.alu_src_a = ASRC_OLD;
        ctrl.alu_src_b = BSRC_IMM;
        ctrl.imn_src = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write = 1'b1;
        ctrl.retire = 1'b1;
      end
      S_TRAP: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle RV32 control FSM (fetch/decode/exec/mem/writeback, trap on bad opcode)
module unidad_control_multiciclo
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       reg_write,
  output logic       imn_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state_dbg
);
  logic [3:0] state_q, state_d;
  ctrl_t ctrl_raw, ctrl;
  always_comb begin
    case (state_q)
      S_FETCH:      state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:     state_d = decode_next(opcode);
      S_MEMADR:     state_d = S_MEMREAD;
      S_MEMREAD:    state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:      state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_LUI,
      S_EXEC_AUIPC: state_d = S_ALUWB;
      S_ALUWB:      state_d = S_FETCH;
      default:      state_d = S_TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  control_salidas u_salidas (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );
  // Reset masks every output combinationally so an in-flight request drops the same cycle.
  assign ctrl       = reset ? '0 : ctrl_raw;
  assign state_dbg  = reset ? 4'd0 : state_q;
  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign mem_read   = ctrl.mem_read;
  assign reg_write  = ctrl.reg_write;
  assign imn_src    = ctrl.imn_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign retire     = ctrl.retire;
  assign illegal    = ctrl.illegal;
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: directed cycle-by-cycle check of every control output and state code
module tb_unidad_control_multiciclo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic mem_ready = 1'b1;
  logic pc_write, ir_write, adr_src, mem_read, reg_write, imn_src, retire, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state_dbg;
  logic [19:0] obs;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  unidad_control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
    .reg_write(reg_write), .imn_src(imn_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .retire(retire), .illegal(illegal),
    .state_dbg(state_dbg)
  );
  assign obs = {pc_write, ir_write, adr_src, mem_read, reg_write, imn_src, alu_src_a,
                alu_src_b, alu_op, result_src, retire, illegal, state_dbg};
  function automatic logic [19:0] mk(input logic pcw, irw, adr, mr, rw, imn,
                                     input logic [1:0] a, b, op, res,
                                     input logic ret, ill, input logic [3:0] st);
    return {pcw, irw, adr, mr, rw, imn, a, b, op, res, ret, ill, st};
  endfunction
  // {pcw irw adr mr rw imn a b op res ret ill st}
  localparam logic [19:0] E_RST    = 20'h0;
  localparam logic [19:0] E_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,4'd0};
  localparam logic [19:0] E_FRDY   = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0,4'd0};
  localparam logic [19:0] E_DEC    = {16'h0, 4'd1};
  localparam logic [19:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0,4'd2};
  localparam logic [19:0] E_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,4'd3};
  localparam logic [19:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b01,1'b1,1'b0,4'd4};
  localparam logic [19:0] E_EXR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,4'd5};
  localparam logic [19:0] E_EXI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b11,2'b00,1'b0,1'b0,4'd6};
  localparam logic [19:0] E_LUI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,2'b01,2'b00,2'b00,1'b0,1'b0,4'd7};
  localparam logic [19:0] E_AUIPC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0,4'd8};
  localparam logic [19:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,4'd9};
  localparam logic [19:0] E_TRAP   = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,4'd10);
  task automatic step(input string tag, input logic rst, input logic mr, input logic [19:0] exp);
    reset = rst;
    mem_ready = mr;
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    step("rst0", 1, 1, E_RST);
    step("rst1", 1, 1, E_RST);
    opcode = 7'b0110011;
    step("r_fetch", 0, 1, E_FRDY);
    step("r_decode", 0, 1, E_DEC);
    step("r_exec", 0, 1, E_EXR);
    step("r_wb", 0, 1, E_ALUWB);
    step("lui_fetch", 0, 1, E_FRDY);
    opcode = 7'b0110111;
    step("lui_decode", 0, 1, E_DEC);
    step("lui_exec", 0, 1, E_LUI);
    step("lui_wb", 0, 1, E_ALUWB);
    step("auipc_fetch", 0, 1, E_FRDY);
    opcode = 7'b0010111;
    step("auipc_decode", 0, 1, E_DEC);
    step("auipc_exec", 0, 1, E_AUIPC);
    step("auipc_wb", 0, 1, E_ALUWB);
    step("i_fetch", 0, 1, E_FRDY);
    opcode = 7'b0010011;
    step("i_decode", 0, 1, E_DEC);
    step("i_exec", 0, 1, E_EXI);
    step("i_wb", 0, 1, E_ALUWB);
    opcode = 7'b0000011;
    step("lw_fwait0", 0, 0, E_FWAIT);
    step("lw_fwait1", 0, 0, E_FWAIT);
    step("lw_fwait2", 0, 0, E_FWAIT);
    step("lw_fetch", 0, 1, E_FRDY);
    step("lw_decode", 0, 0, E_DEC);
    step("lw_memadr", 0, 1, E_MEMADR);
    step("lw_mrwait0", 0, 0, E_MEMRD);
    step("lw_mrwait1", 0, 0, E_MEMRD);
    step("lw_memread", 0, 1, E_MEMRD);
    step("lw_memwb", 0, 0, E_MEMWB);
    step("ill_fetch", 0, 1, E_FRDY);
    opcode = 7'b1100011;
    step("ill_decode", 0, 1, E_DEC);
    for (int i = 0; i < 20; i++) step("trap_hold", 0, i[0], E_TRAP);
    step("trap_reset", 1, 1, E_RST);
    opcode = 7'b0000011;
    step("post_trap_fetch", 0, 1, E_FRDY);
    step("mid_decode", 0, 1, E_DEC);
    step("mid_memadr", 0, 0, E_MEMADR);
    step("mid_memread", 0, 0, E_MEMRD);
    step("mid_reset", 1, 0, E_RST);
    step("mid_after", 0, 0, E_FWAIT);
    step("mid_after2", 0, 0, E_FWAIT);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
